// File: rtl/wb_arbiter2_if.sv
// Bus-side signals of the two-master Wishbone B4 arbiter.
// slave: the arbiter's view; master: the surrounding system/bench view.
interface wb_arbiter2_if;
  logic m0_cyc;
  logic m1_cyc;
  logic bus_ack;
  logic bus_err;
  logic bus_rty;
  logic sel;
  logic gnt0;
  logic gnt1;
  logic busy;
  logic timeout;

  modport slave (
    input  m0_cyc, m1_cyc, bus_ack, bus_err, bus_rty,
    output sel, gnt0, gnt1, busy, timeout
  );

  modport master (
    output m0_cyc, m1_cyc, bus_ack, bus_err, bus_rty,
    input  sel, gnt0, gnt1, busy, timeout
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 round-robin arbiter, grant held for the whole CYC.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter2_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state, nxt;
  logic       last_gnt;
  logic       sel_q, gnt0_q, gnt1_q, busy_q;
  logic       resp;

  assign resp = bus.bus_ack | bus.bus_err | bus.bus_rty;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.m0_cyc && bus.m1_cyc) nxt = last_gnt ? GNT0 : GNT1;
        else if (bus.m0_cyc)          nxt = GNT0;
        else if (bus.m1_cyc)          nxt = GNT1;
      end
      GNT0: begin
        if (!bus.m0_cyc) nxt = bus.m1_cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!bus.m1_cyc) nxt = bus.m0_cyc ? GNT0 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      sel_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= nxt;
      gnt0_q <= (nxt == GNT0);
      gnt1_q <= (nxt == GNT1);
      busy_q <= (nxt != IDLE);
      // sel only moves when ownership is handed to a new master; IDLE keeps it
      if (nxt != state && nxt == GNT0) sel_q <= 1'b0;
      if (nxt != state && nxt == GNT1) sel_q <= 1'b1;
      if (state == GNT0 && nxt != GNT0) last_gnt <= 1'b0;
      if (state == GNT1 && nxt != GNT1) last_gnt <= 1'b1;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic             clr;

  // a grant that is ending or changing hands must not be flagged
  assign clr = (state == IDLE) || (nxt != state) || resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt       <= '0;
        timeout_q <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_ok;
  assign unused_ok   = resp ^ (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with an expected-output scoreboard queue.
module tb_wb_arbiter2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter2_if bus();

  wb_arbiter2 #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic g0;
    logic g1;
    logic sel;
    logic busy;
    logic to;
  } exp_t;

  exp_t q[$];

  // reference model state: owner -1 = nobody
  int   owner;
  bit   last;
  bit   sel_m;
  int   m_cnt;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1'b1;
    sel_m = 1'b0;
    m_cnt = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sel"},  bus.sel,     1'b0);
    chk({tag, "_gnt0"}, bus.gnt0,    1'b0);
    chk({tag, "_gnt1"}, bus.gnt1,    1'b0);
    chk({tag, "_busy"}, bus.busy,    1'b0);
    chk({tag, "_to"},   bus.timeout, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m0_cyc = 0; bus.m1_cyc = 0;
    bus.bus_ack = 0; bus.bus_err = 0; bus.bus_rty = 0;
    model_reset();
    @(posedge clk); #1;
    chk_zero("rst");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    rst = 1'b0;
  endtask

  // drive one cycle, predict the outputs after the next edge, then compare
  task automatic step(bit c0, bit c1, bit ack, bit err);
    int   prev;
    bit   fire;
    exp_t e;
    bus.m0_cyc = c0; bus.m1_cyc = c1;
    bus.bus_ack = ack; bus.bus_err = err; bus.bus_rty = 1'b0;
    prev = owner;
    if (owner == 0) begin
      if (!c0) begin owner = c1 ? 1 : -1; last = 1'b0; end
    end else if (owner == 1) begin
      if (!c1) begin owner = c0 ? 0 : -1; last = 1'b1; end
    end else begin
      if (c0 && c1) owner = last ? 0 : 1;
      else if (c0)  owner = 0;
      else if (c1)  owner = 1;
    end
    if (owner != -1) sel_m = (owner == 1);
    fire = 1'b0;
    if (prev != -1 && owner == prev && !(ack || err)) begin
      if (m_cnt == T - 1) begin fire = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else m_cnt = 0;
`ifndef WB_ARB_TIMEOUT_EN
    fire = 1'b0;
`endif
    e.g0 = (owner == 0); e.g1 = (owner == 1); e.sel = sel_m;
    e.busy = (owner != -1); e.to = fire;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("gnt0", bus.gnt0, e.g0);
    chk("gnt1", bus.gnt1, e.g1);
    chk("sel",  bus.sel,  e.sel);
    chk("busy", bus.busy, e.busy);
    chk("timeout", bus.timeout, e.to);
  endtask

  initial begin
    // reset, then master0 alone two cycles later
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("m0_only_gnt0", bus.gnt0, 1'b1);
    chk("m0_only_sel",  bus.sel,  1'b0);
    chk("m0_only_busy", bus.busy, 1'b1);

    // simultaneous request after reset: master0 first, then direct handoff
    do_reset();
    step(1, 1, 0, 0);
    chk("both_first_gnt0", bus.gnt0, 1'b1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("handoff_gnt1", bus.gnt1, 1'b1);
    chk("handoff_sel",  bus.sel,  1'b1);
    chk("handoff_busy", bus.busy, 1'b1);
    step(0, 0, 0, 0);
    chk("idle_sel_hold", bus.sel, 1'b1);
    step(1, 1, 0, 0);
    chk("alternate_gnt0", bus.gnt0, 1'b1);

    // m1 owns for 20 cycles while m0 toggles its CYC
    step(0, 1, 0, 0);
    chk("m1_owner", bus.gnt1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(i[0], 1, 0, 0);
      chk("hold_sel", bus.sel, 1'b1);
      chk("hold_no_gnt0", bus.gnt0, 1'b0);
    end
    step(1, 0, 0, 0);
    chk("after_hold_gnt0", bus.gnt0, 1'b1);
    // m0 drops and re-raises while m1 waits: m1 must win
    step(0, 1, 0, 0);
    chk("fair_gnt1", bus.gnt1, 1'b1);

    // asynchronous reset between edges while m1 is granted
    #3 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    bus.m0_cyc = 0; bus.m1_cyc = 0;
    @(posedge clk); #1;
    chk_zero("async_rst_hold");
    rst = 1'b0;
    step(0, 1, 0, 0);
    chk("post_rst_gnt1", bus.gnt1, 1'b1);
    step(0, 0, 0, 0);

    // stalled master0: pulse after T granted cycles, ack restarts the count
    step(1, 0, 0, 0);
    for (int k = 1; k <= T + 2; k++) begin
      step(1, 0, 0, 0);
`ifdef WB_ARB_TIMEOUT_EN
      chk("to_pulse", bus.timeout, k == T);
`endif
    end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      step(1, 0, k == 5, 0);
`ifdef WB_ARB_TIMEOUT_EN
      chk("to_after_ack", bus.timeout, k == 13);
`endif
    end
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    // long stall from a fresh grant
    step(1, 0, 0, 0);
    for (int k = 0; k < 2000; k++) begin
      step(1, 0, 0, 0);
`ifndef WB_ARB_TIMEOUT_EN
      chk("stall_to", bus.timeout, 1'b0);
      chk("stall_gnt0", bus.gnt0, 1'b1);
`endif
    end
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master Wishbone B4 arbiter; generates the `sel` input of the two-master WB4 multiplexer that merges CPU fetch (master0) and load/store or debug (master1) onto one shared bus.
- Fair round-robin arbitration, grant held for the whole bus cycle (CYC), direct handoff between masters.
- Optional bus watchdog flags hung transactions.

Parameters:
TIMEOUT_CYCLES, 1023, cycles without ACK/ERR/RTY before watchdog fires; legal range 2..2**CNT_W-1
CNT_W, 10, width of watchdog counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
m0_cyc  input  1  CYC of master0
m1_cyc  input  1  CYC of master1
bus_ack  input  1  ACK returned by the muxed (shared) bus
bus_err  input  1  ERR returned by the muxed bus
bus_rty  input  1  RTY returned by the muxed bus
sel  output  1  mux select; 0 = master0 owns bus, 1 = master1
gnt0  output  1  master0 currently granted
gnt1  output  1  master1 currently granted
busy  output  1  gnt0 | gnt1
timeout  output  1  one-cycle watchdog pulse, to be ORed into granted master's ERR at top level

Behaviour:
- Decided: one clock `clk`; `rst` asynchronous, active-high.
- Reset values:
  - state = IDLE; sel = 0; gnt0 = gnt1 = busy = timeout = 0.
  - last_gnt = 1, so master0 wins the first contention.
- All outputs registered. Grant latency is 1 cycle: request seen at edge N gives gnt at edge N+1.
- States: IDLE, GNT0, GNT1. gnt0/gnt1 are one-hot or both zero, never both 1.
- IDLE:
  - only m0_cyc -> GNT0.
  - only m1_cyc -> GNT1.
  - both -> grant the master != last_gnt.
  - neither -> stay in IDLE; sel holds its previous value.
- GNT0 (sel=0, gnt0=1):
  - stay while m0_cyc = 1.
  - m0_cyc = 0 and m1_cyc = 1 -> GNT1 directly (no idle bubble).
  - m0_cyc = 0 and m1_cyc = 0 -> IDLE.
  - On leaving, last_gnt = 0.
- GNT1: mirror of GNT0; on leaving, last_gnt = 1.
- sel changes only on a state transition into GNT0/GNT1; it never changes while the current owner's CYC is high.
- A master's CYC dropping and rising in consecutive cycles while the other is waiting: the other master is granted first (fairness).
- bus_ack/bus_err/bus_rty are used only by the watchdog; arbitration ignores them.
- Reset asserted mid-cycle: immediate return to reset values; no pending grant survives.

Optional Feature:
Macro: WB_ARB_TIMEOUT_EN
- Defined:
  - CNT_W-bit counter cleared on entering GNT0/GNT1, on any bus_ack|bus_err|bus_rty, and in IDLE.
  - Increments each granted cycle otherwise.
  - When the counter == TIMEOUT_CYCLES-1 and no response arrives that cycle, timeout = 1 for exactly the next cycle and the counter clears.
  - Grant is not revoked; the master is expected to drop CYC on the injected ERR.
  - Counter saturation is impossible by parameter range.
- Undefined: counter logic absent; timeout tied to 0. Arbitration is identical in both builds.

Test Plan:
- Reset release, m0_cyc=1 at cycle 2 -> gnt0=1, sel=0, busy=1 at cycle 3; all outputs 0 during reset.
- m0_cyc and m1_cyc rise together from IDLE after reset -> gnt0 first. m0_cyc drops after 3 cycles -> gnt1=1, sel=1 on the next edge, no IDLE cycle. m1 drops, both request again -> gnt0 (alternation).
- m1 granted with m1_cyc held 20 cycles while m0_cyc pulses -> sel stays 1 for all 20 cycles; gnt0 never asserts until m1_cyc drops.
- rst asserted asynchronously mid-GNT1 (between edges) -> sel, gnt1, busy go 0 immediately. After release with only m1_cyc=1 -> gnt1 one cycle later.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: grant m0 with no ack -> timeout single pulse 8 cycles after grant. Repeat with bus_ack at cycle 5 -> no pulse before cycle 13.
- WB_ARB_TIMEOUT_EN undefined: same stalled transfer for 2000 cycles -> timeout stays 0, gnt0 stays 1.
